// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - timer register map, bit indices and service FSM states
package timer_regs_pkg;

    localparam logic [7:0] ADDR_OVERFLOW   = 8'h00;
    localparam logic [7:0] ADDR_COUNTER    = 8'h04;
    localparam logic [7:0] ADDR_CONTROL    = 8'h08;
    localparam logic [7:0] ADDR_COMPARE    = 8'h0C;
    localparam logic [7:0] ADDR_INT_STATUS = 8'h10;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_CMP_EN   = 2;
    localparam int CTRL_OVF_EN   = 3;

    localparam int STAT_OVF = 0;
    localparam int STAT_CMP = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_OVF,
        ST_WR_CMP,
        ST_WR_CTRL,
        ST_RUN,
        ST_RD_STAT,
        ST_WT_STAT,
        ST_RD_CNT,
        ST_WT_CNT,
        ST_WR_STOP
    } tsm_state_e;

endpackage

// File: rtl/timer_service_master_if.sv
// rtl/timer_service_master_if.sv - timer register bus between service master and timer slave
interface timer_service_master_if;

    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;

    modport master (
        output bus_write_en,
        output bus_read_en,
        output bus_addr,
        output bus_write_data,
        input  bus_read_data
    );

    modport slave (
        input  bus_write_en,
        input  bus_read_en,
        input  bus_addr,
        input  bus_write_data,
        output bus_read_data
    );

endinterface

// File: rtl/timer_service_master.sv
// rtl/timer_service_master.sv - programs the timer, services its interrupt, snapshots and stops it
module timer_service_master
    import timer_regs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    pclk,
    input  logic                    nreset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    snap_req,
    input  logic [31:0]             cfg_overflow,
    input  logic [31:0]             cfg_compare,
    input  logic [3:0]              cfg_ctrl,
    input  logic                    fabint,
    timer_service_master_if.master  bus,
    output logic                    running,
    output logic                    evt_valid,
    output logic [1:0]              evt_status,
    output logic [CNT_W-1:0]        ovf_count,
    output logic [CNT_W-1:0]        cmp_count,
    output logic                    snap_valid,
    output logic [31:0]             snap_value
);

    tsm_state_e  state;
    tsm_state_e  nextState;
    logic [31:0] cfgOverflow;
    logic [31:0] cfgCompare;
    logic [3:0]  cfgCtrl;
    logic        irqPend;
    logic        snapPend;
    logic        enterRdStat;
    logic        enterRdCnt;

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // stop outranks a pending interrupt, which outranks a pending snapshot
    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE:    if (start) nextState = ST_WR_OVF;
            ST_WR_OVF:  nextState = ST_WR_CMP;
            ST_WR_CMP:  nextState = ST_WR_CTRL;
            ST_WR_CTRL: nextState = ST_RUN;
            ST_RUN: begin
                if (stop)          nextState = ST_WR_STOP;
                else if (irqPend)  nextState = ST_RD_STAT;
                else if (snapPend) nextState = ST_RD_CNT;
            end
            ST_RD_STAT: nextState = ST_WT_STAT;
            ST_WT_STAT: nextState = ST_RUN;
            ST_RD_CNT:  nextState = ST_WT_CNT;
            ST_WT_CNT:  nextState = ST_RUN;
            ST_WR_STOP: nextState = ST_IDLE;
            default:    nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.bus_write_en   = 1'b0;
        bus.bus_read_en    = 1'b0;
        bus.bus_addr       = 8'h00;
        bus.bus_write_data = 32'd0;
        running            = 1'b0;
        unique case (state)
            ST_WR_OVF: begin
                bus.bus_write_en   = 1'b1;
                bus.bus_addr       = ADDR_OVERFLOW;
                bus.bus_write_data = cfgOverflow;
            end
            ST_WR_CMP: begin
                bus.bus_write_en   = 1'b1;
                bus.bus_addr       = ADDR_COMPARE;
                bus.bus_write_data = cfgCompare;
            end
            ST_WR_CTRL: begin
                bus.bus_write_en   = 1'b1;
                bus.bus_addr       = ADDR_CONTROL;
                bus.bus_write_data = {28'd0, cfgCtrl};
            end
            ST_WR_STOP: begin
                bus.bus_write_en   = 1'b1;
                bus.bus_addr       = ADDR_CONTROL;
            end
            ST_RD_STAT: begin
                bus.bus_read_en    = 1'b1;
                bus.bus_addr       = ADDR_INT_STATUS;
                running            = 1'b1;
            end
            ST_RD_CNT: begin
                bus.bus_read_en    = 1'b1;
                bus.bus_addr       = ADDR_COUNTER;
                running            = 1'b1;
            end
            ST_RUN, ST_WT_STAT, ST_WT_CNT: running = 1'b1;
            default: ;
        endcase
    end

    assign enterRdStat = (state == ST_RUN) && (nextState == ST_RD_STAT);
    assign enterRdCnt  = (state == ST_RUN) && (nextState == ST_RD_CNT);

    // a new request on the clearing edge must survive, so set wins over clear
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            cfgOverflow <= 32'd0;
            cfgCompare  <= 32'd0;
            cfgCtrl     <= 4'd0;
            irqPend     <= 1'b0;
            snapPend    <= 1'b0;
            evt_valid   <= 1'b0;
            evt_status  <= 2'b00;
            ovf_count   <= '0;
            cmp_count   <= '0;
            snap_valid  <= 1'b0;
            snap_value  <= 32'd0;
        end else begin
            irqPend    <= fabint | (irqPend & ~enterRdStat);
            snapPend   <= snap_req | (snapPend & ~enterRdCnt);
            evt_valid  <= (state == ST_WT_STAT);
            snap_valid <= (state == ST_WT_CNT);
            if (state == ST_IDLE && start) begin
                cfgOverflow <= cfg_overflow;
                cfgCompare  <= cfg_compare;
                cfgCtrl     <= cfg_ctrl;
            end
            if (state == ST_WT_STAT) begin
                evt_status <= bus.bus_read_data[1:0];
                ovf_count  <= ovf_count + CNT_W'(bus.bus_read_data[STAT_OVF]);
                cmp_count  <= cmp_count + CNT_W'(bus.bus_read_data[STAT_CMP]);
            end
            if (state == ST_WT_CNT) begin
                snap_value <= bus.bus_read_data;
            end
        end
    end

endmodule
